// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive endpoint: FSM encoding, default
// sizing and the idle levels the input synchronisers reset to.
package spi_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W           = 5;

  localparam logic CS_IDLE   = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic DATA_IDLE = 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus an edge-detect flop.
// Edges are masked until the pipeline holds only real pin samples.
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic IDLE   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;
  logic [STAGES:0]   warm_r;

  // Synchroniser chain, edge-detect flop and warm-up tracker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {STAGES{IDLE}};
      prev_r <= IDLE;
      warm_r <= {(STAGES + 1){1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      prev_r <= sync_r[STAGES-1];
      warm_r <= {warm_r[STAGES-1:0], 1'b1};
    end
  end

  // The reset value of the chain is not a real sample, so an edge against
  // it (e.g. leaving reset with the pin already active) must not count.
  assign level = sync_r[STAGES-1];
  assign rise  = warm_r[STAGES] & level & ~prev_r;
  assign fall  = warm_r[STAGES] & ~level & prev_r;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI peripheral-side receiver: assembles DATA_W-bit words, valid/ready output.
// Build option SPI_RX_LSB_FIRST_EN selects LSB-first shifting (default MSB-first).
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_cs_l,
  input  logic              spi_sclk,
  input  logic              spi_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              frame_err,
  output logic [4:0]        bit_count
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic data_level_s, data_rise_s, data_fall_s;
  logic unused_s;

  state_t            state_r;
  logic [DATA_W-1:0] shreg_r;
  logic [CNT_W-1:0]  bit_count_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              rx_valid_r;
  logic              rx_overrun_r;
  logic              frame_err_r;

  logic [DATA_W-1:0] shreg_next_s;
  logic              sample_s;
  logic              word_done_s;
  logic              accept_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(CS_IDLE)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .din(spi_cs_l),
    .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(SCLK_IDLE)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .din(spi_sclk),
    .level(sclk_level_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(DATA_IDLE)) u_sync_data (
    .clk(clk), .reset_n(reset_n), .din(spi_data),
    .level(data_level_s), .rise(data_rise_s), .fall(data_fall_s)
  );

  assign unused_s = ^{sclk_level_s, sclk_fall_s, data_rise_s, data_fall_s};

  // Next shift-register value and word-completion / handshake qualifiers.
  always_comb begin
`ifdef SPI_RX_LSB_FIRST_EN
    shreg_next_s = {data_level_s, shreg_r[DATA_W-1:1]};
`else
    shreg_next_s = {shreg_r[DATA_W-2:0], data_level_s};
`endif
    // A cs rise in the same clock blocks the sample (cs_level is then 1).
    sample_s    = (state_r == ST_SHIFT) && sclk_rise_s && !cs_level_s;
    word_done_s = sample_s && (bit_count_r == LAST_BIT);
    accept_s    = rx_valid_r && rx_ready;
  end

  // Frame FSM, shifter, bit counter and the registered output handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      shreg_r      <= {DATA_W{1'b0}};
      bit_count_r  <= {CNT_W{1'b0}};
      rx_data_r    <= {DATA_W{1'b0}};
      rx_valid_r   <= 1'b0;
      rx_overrun_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      rx_overrun_r <= 1'b0;
      frame_err_r  <= 1'b0;

      if (word_done_s) begin
        rx_data_r  <= shreg_next_s;
        rx_valid_r <= 1'b1;
        if (rx_valid_r && !rx_ready) begin
          rx_overrun_r <= 1'b1;
        end
      end else if (accept_s) begin
        rx_valid_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_r     <= ST_SHIFT;
            bit_count_r <= {CNT_W{1'b0}};
            shreg_r     <= {DATA_W{1'b0}};
          end
        end
        ST_SHIFT: begin
          if (cs_rise_s) begin
            state_r     <= ST_IDLE;
            bit_count_r <= {CNT_W{1'b0}};
            if (bit_count_r != {CNT_W{1'b0}}) begin
              frame_err_r <= 1'b1;
            end
          end else if (sample_s) begin
            shreg_r <= shreg_next_s;
            if (bit_count_r == LAST_BIT) begin
              bit_count_r <= {CNT_W{1'b0}};
            end else begin
              bit_count_r <= bit_count_r + 5'd1;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          bit_count_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign rx_overrun = rx_overrun_r;
  assign frame_err  = frame_err_r;
  assign bit_count  = bit_count_r;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: directed scenarios plus random frames,
// with a monitor popping expected words whenever the DUT hands one over.
module tb_spi_slave_rx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_cs_l = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_data = 1'b0;
  logic        ready_force = 1'b0;
  logic        rand_en = 1'b0;
  logic        rand_bit = 1'b1;
  logic        rx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_overrun;
  logic        frame_err;
  logic [4:0]  bit_count;

  int n_chk = 0;
  int n_pass = 0;
  int exp_ovr = 0;
  int seen_ovr = 0;
  int exp_ferr = 0;
  int seen_ferr = 0;
  int valid_cyc = 0;
  logic [15:0] exp_q[$];

  assign rx_ready = rand_en ? rand_bit : ready_force;

  spi_slave_rx #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .spi_cs_l(spi_cs_l), .spi_sclk(spi_sclk),
    .spi_data(spi_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_overrun(rx_overrun), .frame_err(frame_err),
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rand_bit <= ($urandom_range(0, 3) != 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Word value the stream should produce: the k-th bit on the wire lands at
  // position 15-k (MSB first) or k (LSB first).
  function automatic logic [15:0] model_word(input logic [15:0] s);
    logic [15:0] w;
    w = 16'h0000;
    for (int k = 0; k < 16; k++) begin
`ifdef SPI_RX_LSB_FIRST_EN
      w[k] = s[15-k];
`else
      w[15-k] = s[15-k];
`endif
    end
    return w;
  endfunction

  // Monitor: pulse counters and scoreboard pop on every accepted word.
  always @(negedge clk) begin
    if (rx_overrun === 1'b1) seen_ovr++;
    if (frame_err === 1'b1) seen_ferr++;
    if (rx_valid === 1'b1) valid_cyc++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_word: got %h, expected no word", rx_data);
      end else begin
        chk("rx_data", {16'h0000, rx_data}, {16'h0000, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic collide);
    spi_data = b;
    tick(2);
    spi_sclk = 1'b1;
    if (collide) begin
      // Ready high exactly during the clock in which the word completes.
      tick(2);
      ready_force = 1'b1;
      tick(1);
      ready_force = 1'b0;
      tick(1);
    end else begin
      tick(4);
    end
    spi_sclk = 1'b0;
    tick(2);
  endtask

  task automatic send_word(input logic [15:0] s, input int nbits, input logic ovr,
                           input logic collide);
    if (nbits == 16) begin
      if (ovr) begin
        void'(exp_q.pop_back());
        exp_ovr++;
      end
      exp_q.push_back(model_word(s));
    end
    for (int i = 0; i < nbits; i++) send_bit(s[15-i], collide && (i == nbits - 1));
  endtask

  task automatic cs_low();
    spi_cs_l = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    spi_cs_l = 1'b1;
    tick(6);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_overrun"}, seen_ovr, exp_ovr);
    chk({name, "_frame_err"}, seen_ferr, exp_ferr);
    chk({name, "_bit_count"}, {27'd0, bit_count}, 0);
  endtask

  initial begin
    int v0;
    logic [15:0] s;
    int nw;

    tick(3);
    chk("reset_valid", {31'd0, rx_valid}, 0);
    chk("reset_data", {16'h0000, rx_data}, 0);
    chk("reset_count", {27'd0, bit_count}, 0);
    chk("reset_pulses", {30'd0, rx_overrun, frame_err}, 0);
    reset_n = 1'b1;
    tick(5);

    // Single word, consumer always ready.
    ready_force = 1'b1;
    v0 = valid_cyc;
    cs_low();
    send_word(16'hA5C3, 16, 1'b0, 1'b0);
    cs_high();
    drain("single");
    chk("single_valid_cycles", valid_cyc - v0, 1);

    // Partial frame then a clean word.
    cs_low();
    send_word(16'hFFFF, 9, 1'b0, 1'b0);
    exp_ferr++;
    cs_high();
    cs_low();
    send_word(16'h0001, 16, 1'b0, 1'b0);
    cs_high();
    drain("frame_err");

    // Back-to-back words with the consumer stalled.
    ready_force = 1'b0;
    cs_low();
    send_word(16'h1234, 16, 1'b0, 1'b0);
    send_word(16'hFEDC, 16, 1'b1, 1'b0);
    cs_high();
    chk("overrun_valid_held", {31'd0, rx_valid}, 1);
    ready_force = 1'b1;
    drain("overrun");

    // Accept in the same clock a new word completes.
    ready_force = 1'b0;
    cs_low();
    send_word(16'h5A5A, 16, 1'b0, 1'b0);
    send_word(16'h3C96, 16, 1'b0, 1'b1);
    cs_high();
    chk("collide_valid_held", {31'd0, rx_valid}, 1);
    ready_force = 1'b1;
    drain("collide");

    // Bit-order: a single leading one.
    cs_low();
    send_word(16'h8000, 16, 1'b0, 1'b0);
    cs_high();
    drain("order");
`ifdef SPI_RX_LSB_FIRST_EN
    s = 16'h0001;
`else
    s = 16'h8000;
`endif
    chk("order_rx_data", {16'h0000, rx_data}, {16'h0000, s});

    // Reset in the middle of a frame, cs_l held low afterwards.
    cs_low();
    s = 16'($urandom());
    send_word(s, 7, 1'b0, 1'b0);
    chk("pre_reset_count", {27'd0, bit_count}, 7);
    reset_n = 1'b0;
    #2;
    chk("mid_reset_data", {16'h0000, rx_data}, 0);
    chk("mid_reset_count", {27'd0, bit_count}, 0);
    chk("mid_reset_valid", {31'd0, rx_valid}, 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    chk("post_reset_idle_count", {27'd0, bit_count}, 0);
    cs_high();
    seen_ovr = 0;
    seen_ferr = 0;
    exp_ovr = 0;
    exp_ferr = 0;
    cs_low();
    send_word(16'($urandom()), 16, 1'b0, 1'b0);
    cs_high();
    drain("post_reset");

    // Random frames with a randomly stalling consumer.
    rand_en = 1'b1;
    for (int f = 0; f < 25; f++) begin
      cs_low();
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) send_word(16'($urandom()), 16, 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        send_word(16'($urandom()), $urandom_range(1, 15), 1'b0, 1'b0);
        exp_ferr++;
      end
      cs_high();
    end
    rand_en = 1'b0;
    ready_force = 1'b1;
    drain("random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
